// File: rtl/conv_pool_pkg.sv
// Shared types and helpers for the binary-activation conv + max-pool engine.
package conv_pool_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    REDUCE,
    OUT
  } state_t;

  // Index width that never collapses to zero bits for a count of one.
  function automatic int idx_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic signed [31:0] sat_scale(
    input logic signed [31:0] v,
    input int                 shift,
    input int                 out_bits
  );
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] r;
    s  = v >>> shift;
    hi = (32'sd1 <<< (out_bits - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    r  = s;
    if (s > hi) r = hi;
    if (s < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/conv_pool_engine_max_tree.sv
// Signed max / argmax over COUNT packed values; lowest index wins ties.
module max_tree #(
  parameter int WIDTH    = 6,
  parameter int COUNT    = 9,
  parameter int IDX_BITS = 4
) (
  input  logic [COUNT*WIDTH-1:0] vals,
  output logic [WIDTH-1:0]       max_val,
  output logic [IDX_BITS-1:0]    max_idx
);

  always_comb begin
    max_val = vals[WIDTH-1:0];
    max_idx = '0;
    // Strict compare keeps the earlier index on equal values.
    for (int i = 1; i < COUNT; i++) begin
      if ($signed(vals[i*WIDTH +: WIDTH]) > $signed(max_val)) begin
        max_val = vals[i*WIDTH +: WIDTH];
        max_idx = IDX_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/conv_pool_engine.sv
// Binary-activation convolution over N_WIN windows followed by a
// scale/saturate/ReLU stage and a max-pool, delivered on valid/ready.
module conv_pool_engine
  import conv_pool_pkg::*;
#(
  parameter int N_WIN    = 9,
  parameter int K_TAPS   = 9,
  parameter int W_BITS   = 8,
  parameter int ACC_BITS = 12,
  parameter int OUT_BITS = 6,
  parameter int SHIFT    = 6
) (
  input  logic                       clk_i,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       relu_en_i,
  input  logic [K_TAPS*W_BITS-1:0]   weight_i,
  output logic [idx_bits(K_TAPS)-1:0] tap_o,
  input  logic [N_WIN-1:0]           act_i,
  input  logic                       act_valid_i,
  output logic                       act_ready_o,
  output logic [OUT_BITS-1:0]        pool_o,
  output logic [idx_bits(N_WIN)-1:0] pool_win_o,
  output logic                       pool_valid_o,
  input  logic                       pool_ready_i,
  output logic                       busy_o
);

  localparam int TAP_BITS = idx_bits(K_TAPS);
  localparam int WIN_BITS = idx_bits(N_WIN);

  if (ACC_BITS < W_BITS + $clog2(K_TAPS)) begin : g_acc_chk
    $error("ACC_BITS too narrow for W_BITS and K_TAPS");
  end

  state_t state;
  state_t next;

  logic [TAP_BITS-1:0]        tap;
  logic signed [ACC_BITS-1:0] acc [N_WIN];
  logic signed [W_BITS-1:0]   wts [K_TAPS];
  logic                       relu;
  logic signed [W_BITS-1:0]   cur_w;
  logic                       last_tap;
  logic                       beat;
  logic                       take;

  logic [N_WIN*OUT_BITS-1:0] scaled;
  logic [OUT_BITS-1:0]       max_val;
  logic [WIN_BITS-1:0]       max_idx;

  assign tap_o    = tap;
  assign cur_w    = wts[tap];
  assign last_tap = (tap == TAP_BITS'(K_TAPS - 1));
  assign beat     = act_valid_i && act_ready_o;
  assign take     = (state == IDLE) && start_i;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next         = state;
    act_ready_o  = 1'b0;
    pool_valid_o = 1'b0;
    busy_o       = 1'b1;
    unique case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) next = ACCUM;
      end
      ACCUM: begin
        act_ready_o = 1'b1;
        if (act_valid_i && last_tap) next = REDUCE;
      end
      REDUCE: next = OUT;
      OUT: begin
        pool_valid_o = 1'b1;
        if (pool_ready_i) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      tap        <= '0;
      relu       <= 1'b0;
      pool_o     <= '0;
      pool_win_o <= '0;
      for (int i = 0; i < N_WIN; i++) acc[i] <= '0;
      for (int t = 0; t < K_TAPS; t++) wts[t] <= '0;
    end else begin
      if (take) begin
        relu <= relu_en_i;
        tap  <= '0;
        for (int i = 0; i < N_WIN; i++) acc[i] <= '0;
        for (int t = 0; t < K_TAPS; t++)
          wts[t] <= weight_i[t*W_BITS +: W_BITS];
      end
      if (beat) begin
        for (int i = 0; i < N_WIN; i++)
          if (act_i[i]) acc[i] <= acc[i] + ACC_BITS'(cur_w);
        tap <= last_tap ? '0 : tap + TAP_BITS'(1);
      end
      if (state == REDUCE) begin
        pool_o     <= max_val;
        pool_win_o <= max_idx;
      end
    end
  end

  for (genvar i = 0; i < N_WIN; i++) begin : g_scale
    logic signed [31:0]         wide;
    logic signed [OUT_BITS-1:0] s;
    assign wide = {{(32-ACC_BITS){acc[i][ACC_BITS-1]}}, acc[i]};
    assign s    = OUT_BITS'(sat_scale(wide, SHIFT, OUT_BITS));
    assign scaled[i*OUT_BITS +: OUT_BITS] =
      (relu && s[OUT_BITS-1]) ? '0 : s;
  end

  max_tree #(
    .WIDTH   (OUT_BITS),
    .COUNT   (N_WIN),
    .IDX_BITS(WIN_BITS)
  ) u_max (
    .vals   (scaled),
    .max_val(max_val),
    .max_idx(max_idx)
  );

endmodule

// File: tb/tb_conv_pool_engine.sv
// Bench for conv_pool_engine: default and SHIFT=4 instances share stimulus
// and are checked against an arithmetic reference model.
module tb_conv_pool_engine;

  localparam int N = 9;
  localparam int K = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_i = 1'b0;
  logic         relu_en_i = 1'b0;
  logic [K*8-1:0] weight_i = '0;
  logic [N-1:0] act_i = '0;
  logic         act_valid_i = 1'b0;
  logic         pool_ready_i = 1'b0;

  logic [3:0] tap_a, tap_b, win_a, win_b;
  logic [5:0] pool_a, pool_b;
  logic       rdy_a, rdy_b, pv_a, pv_b, busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  int         wts  [K];
  logic [N-1:0] acts [K];
  bit         relu_l;

  always #5 clk = ~clk;

  conv_pool_engine dut_a (
    .clk_i(clk), .rst(rst), .start_i(start_i), .relu_en_i(relu_en_i),
    .weight_i(weight_i), .tap_o(tap_a), .act_i(act_i),
    .act_valid_i(act_valid_i), .act_ready_o(rdy_a), .pool_o(pool_a),
    .pool_win_o(win_a), .pool_valid_o(pv_a), .pool_ready_i(pool_ready_i),
    .busy_o(busy_a)
  );

  conv_pool_engine #(.SHIFT(4)) dut_b (
    .clk_i(clk), .rst(rst), .start_i(start_i), .relu_en_i(relu_en_i),
    .weight_i(weight_i), .tap_o(tap_b), .act_i(act_i),
    .act_valid_i(act_valid_i), .act_ready_o(rdy_b), .pool_o(pool_b),
    .pool_win_o(win_b), .pool_valid_o(pv_b), .pool_ready_i(pool_ready_i),
    .busy_o(busy_b)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Floor-divide by 2^shift, clamp to 6-bit signed, optional ReLU, then
  // pick the largest window, earliest one on ties.
  task automatic model(input int shift, output int p, output int win);
    int d, sum, s;
    d = 1 << shift;
    p = 0;
    win = 0;
    for (int i = 0; i < N; i++) begin
      sum = 0;
      for (int t = 0; t < K; t++) if (acts[t][i]) sum += wts[t];
      s = (sum >= 0) ? sum / d : -((-sum + d - 1) / d);
      if (s > 31) s = 31;
      if (s < -32) s = -32;
      if (relu_l && s < 0) s = 0;
      if (i == 0 || s > p) begin
        p = s;
        win = i;
      end
    end
  endtask

  function automatic logic [K*8-1:0] pack();
    logic [K*8-1:0] v;
    for (int t = 0; t < K; t++) v[t*8 +: 8] = 8'(wts[t]);
    return v;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_rdy"}, rdy_a, 0);
    chk({tag, "_pv"}, pv_a, 0);
    chk({tag, "_tap"}, tap_a, 0);
    chk({tag, "_pool"}, $signed(pool_a), 0);
    chk({tag, "_win"}, win_a, 0);
    chk({tag, "_pool_b"}, $signed(pool_b), 0);
  endtask

  // Latency is counted in cycles from the cycle that presents start_i
  // (cycle 0) to the first cycle showing pool_valid_o.
  task automatic run(input string tag, input bit relu, input int bub_a,
                     input int bub_b, input int hold, input bit poke);
    int cyc, t, pa, wa, pb, wb, nb;
    bit got, ba, bb;
    relu_l = relu;
    model(6, pa, wa);
    model(4, pb, wb);
    nb = (bub_a >= 0 ? 1 : 0) + (bub_b >= 0 ? 1 : 0);
    @(posedge clk); #1;
    start_i = 1'b1; relu_en_i = relu; weight_i = pack();
    act_valid_i = 1'b0; act_i = '0; pool_ready_i = 1'b0;
    cyc = 0; t = 0; got = 0; ba = 0; bb = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      start_i = 1'b0;
      act_valid_i = 1'b0;
      act_i = '0;
      if (t < K) begin
        if (t == bub_a && !ba) ba = 1;
        else if (t == bub_b && !bb) bb = 1;
        else begin
          act_valid_i = 1'b1;
          act_i = acts[t];
        end
      end
      @(negedge clk);
      if (act_valid_i) begin
        if (t == 0 || t == K - 1) begin
          chk({tag, "_tap"}, tap_a, t);
          chk({tag, "_rdy"}, rdy_a, 1);
        end
        t++;
      end
      if (pv_a) got = 1;
    end
    act_valid_i = 1'b0;
    chk({tag, "_lat"}, cyc, 11 + nb);
    chk({tag, "_pool"}, $signed(pool_a), pa);
    chk({tag, "_win"}, win_a, wa);
    chk({tag, "_pool_s4"}, $signed(pool_b), pb);
    chk({tag, "_win_s4"}, win_b, wb);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      start_i = poke;
      @(negedge clk);
      chk({tag, "_hold_pv"}, pv_a, 1);
      chk({tag, "_hold_pool"}, $signed(pool_a), pa);
      chk({tag, "_hold_busy"}, busy_a, 1);
    end
    @(posedge clk); #1;
    pool_ready_i = 1'b1;
    start_i = poke;
    @(posedge clk); #1;
    pool_ready_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_done_pv"}, pv_a, 0);
    chk({tag, "_done_busy"}, busy_a, 0);
    chk({tag, "_done_pv_s4"}, pv_b, 0);
  endtask

  task automatic fill(input int w, input logic [N-1:0] a);
    for (int t = 0; t < K; t++) begin
      wts[t] = w;
      acts[t] = a;
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    fill(127, '1);
    run("pos127", 0, -1, -1, 0, 0);

    fill(-128, '1);
    run("neg128", 0, -1, -1, 0, 0);
    run("neg128_relu", 1, -1, -1, 0, 0);

    fill(0, '0);
    wts[0] = 64;
    acts[0] = 9'b0_0010_0000;
    run("onehot5", 0, -1, -1, 0, 0);

    fill(127, '1);
    wts[3] = -20;
    acts[4] = 9'b1_0101_0101;
    run("bp", 0, 2, 6, 3, 1);

    // Abort a run mid-accumulation while tap 4 is on the bus.
    for (int t = 0; t < K; t++) begin
      wts[t] = int'($urandom_range(0, 255)) - 128;
      acts[t] = N'($urandom);
    end
    @(posedge clk); #1;
    start_i = 1'b1; relu_en_i = 1'b0; weight_i = pack();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      act_valid_i = 1'b1;
      act_i = acts[k];
    end
    #2 rst = 1'b1;
    #1 check_reset("abort");
    act_valid_i = 1'b0;
    act_i = '0;
    @(negedge clk);
    rst = 1'b0;

    fill(0, '0);
    wts[0] = 64;
    wts[1] = -64;
    acts[0] = 9'b0_0000_1000;
    acts[1] = 9'b1_1111_0111;
    run("fresh", 0, -1, -1, 1, 0);

    for (int r = 0; r < 8; r++) begin
      for (int t = 0; t < K; t++) begin
        wts[t] = int'($urandom_range(0, 255)) - 128;
        acts[t] = N'($urandom);
      end
      run("rand", bit'($urandom_range(0, 1)),
          (r % 3 == 0) ? int'($urandom_range(0, K - 1)) : -1, -1,
          int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
